// File: rtl/llr_pkg.sv
// rtl/llr_pkg.sv - shared constants and helpers for the channel-LLR bank loader
package llr_pkg;

  localparam int LLR_SEQ       = 0;
  localparam int LLR_RR        = 1;
  localparam int LLR_W_DEF     = 11;
  localparam int NUM_BANKS_DEF = 10;
  localparam int DEPTH_DEF     = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/llr_bank_loader_if.sv
// rtl/llr_bank_loader_if.sv - LLR input stream plus bank write bus of the loader
interface llr_bank_loader_if #(
  parameter int LLR_W     = 11,
  parameter int NUM_BANKS = 10,
  parameter int ADDR_W    = 6
);
  logic                 input_en;
  logic [LLR_W-1:0]     data_in;
  logic                 in_ready;
  logic [LLR_W-1:0]     data_Lch;
  logic [ADDR_W-1:0]    wr_addr_Lch;
  logic                 wr_addr_high_Lch;
  logic [NUM_BANKS-1:0] wren_Lch;

  modport master (
    output input_en, data_in,
    input  in_ready, data_Lch, wr_addr_Lch, wr_addr_high_Lch, wren_Lch
  );

  modport slave (
    input  input_en, data_in,
    output in_ready, data_Lch, wr_addr_Lch, wr_addr_high_Lch, wren_Lch
  );
endinterface

// File: rtl/llr_page_ctrl.sv
// rtl/llr_page_ctrl.sv - ping-pong page bookkeeping: write/read page and count of complete pages
module llr_page_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       commit_i,
  input  logic       ack_i,
  output logic       wr_page_o,
  output logic       rd_page_o,
  output logic       data_ready_o,
  output logic       commit_pend_o,
  output logic       ack_ok_o,
  output logic [1:0] full_cnt_o
);
  logic       wr_page_q, wr_page_d;
  logic       rd_page_q, rd_page_d;
  logic       pend_q, pend_d;
  logic [1:0] full_q, full_d;
  logic       ack_ok;

  // The page count lags the write-page toggle by one edge, so a finished page becomes
  // visible to the decoder only after its final write has landed.
  always_comb begin
    ack_ok    = ack_i && (full_q != 2'd0);
    wr_page_d = wr_page_q ^ commit_i;
    rd_page_d = rd_page_q ^ ack_ok;
    pend_d    = commit_i;
    full_d    = full_q;
    if (pend_q && !ack_ok) full_d = full_q + 2'd1;
    else if (!pend_q && ack_ok) full_d = full_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_page_q <= 1'b0;
      rd_page_q <= 1'b0;
      pend_q    <= 1'b0;
      full_q    <= 2'd0;
    end else begin
      wr_page_q <= wr_page_d;
      rd_page_q <= rd_page_d;
      pend_q    <= pend_d;
      full_q    <= full_d;
    end
  end

  assign wr_page_o     = wr_page_q;
  assign rd_page_o     = rd_page_q;
  assign data_ready_o  = (full_q != 2'd0);
  assign commit_pend_o = pend_q;
  assign ack_ok_o      = ack_ok;
  assign full_cnt_o    = full_q;
endmodule

// File: rtl/llr_bank_loader.sv
// rtl/llr_bank_loader.sv - scatters channel LLR words over NUM_BANKS bank RAMs with two ping-pong pages
module llr_bank_loader
  import llr_pkg::*;
#(
  parameter int LLR_W      = LLR_W_DEF,
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int INTERLEAVE = LLR_SEQ
) (
  input  logic             wrclk,
  input  logic             reset,
  input  logic             start_read,
  input  logic             frame_lock,
  llr_bank_loader_if.slave bus,
  output logic             data_ready,
  output logic             rd_page,
  input  logic             data_ack,
  output logic             overflow,
  output logic             frame_abort
);
  localparam int ADDR_W = clog2(DEPTH);
  localparam int BANK_W = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1;

  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LLR_W-1:0]     data_q, data_d;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic                 wpage_q, wpage_d;
  logic [NUM_BANKS-1:0] wren_q, wren_d;
  logic                 overflow_q, overflow_d;
  logic                 abort_q, abort_d;

  logic       wr_page, commit_pend, ack_ok;
  logic [1:0] full_cnt;
  logic       stall, ready, accept, bank_last, addr_last, frame_end, pos_nz;

  // A commit still in flight counts as a page: with one page already full it would fill both.
  assign stall     = (full_cnt == 2'd2) || ((full_cnt == 2'd1) && commit_pend && !ack_ok);
  assign ready     = start_read && frame_lock && !stall;
  assign accept    = bus.input_en && ready;
  assign bank_last = (bank_q == BANK_W'(NUM_BANKS - 1));
  assign addr_last = (addr_q == ADDR_W'(DEPTH - 1));
  assign frame_end = accept && bank_last && addr_last;
  assign pos_nz    = (bank_q != '0) || (addr_q != '0);

  always_comb begin
    bank_d     = bank_q;
    addr_d     = addr_q;
    abort_d    = 1'b0;
    overflow_d = overflow_q || (bus.input_en && !ready && start_read && frame_lock);
    if (!frame_lock) begin
      bank_d  = '0;
      addr_d  = '0;
      abort_d = pos_nz;
    end else if (frame_end) begin
      bank_d = '0;
      addr_d = '0;
    end else if (accept) begin
      if (INTERLEAVE == LLR_RR) begin
        if (bank_last) begin
          bank_d = '0;
          addr_d = addr_q + ADDR_W'(1);
        end else begin
          bank_d = bank_q + BANK_W'(1);
        end
      end else begin
        if (addr_last) begin
          addr_d = '0;
          bank_d = bank_q + BANK_W'(1);
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    waddr_d = waddr_q;
    wpage_d = wpage_q;
    wren_d  = '0;
    if (accept) begin
      data_d  = bus.data_in;
      waddr_d = addr_q;
      wpage_d = wr_page;
      wren_d  = NUM_BANKS'(1) << bank_q;
    end
  end

  always_ff @(posedge wrclk) begin
    if (reset) begin
      bank_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      waddr_q    <= '0;
      wpage_q    <= 1'b0;
      wren_q     <= '0;
      overflow_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      waddr_q    <= waddr_d;
      wpage_q    <= wpage_d;
      wren_q     <= wren_d;
      overflow_q <= overflow_d;
      abort_q    <= abort_d;
    end
  end

  llr_page_ctrl u_page_ctrl (
    .clk          (wrclk),
    .reset        (reset),
    .commit_i     (frame_end),
    .ack_i        (data_ack),
    .wr_page_o    (wr_page),
    .rd_page_o    (rd_page),
    .data_ready_o (data_ready),
    .commit_pend_o(commit_pend),
    .ack_ok_o     (ack_ok),
    .full_cnt_o   (full_cnt)
  );

  assign bus.in_ready         = ready;
  assign bus.data_Lch         = data_q;
  assign bus.wr_addr_Lch      = waddr_q;
  assign bus.wr_addr_high_Lch = wpage_q;
  assign bus.wren_Lch         = wren_q;
  assign overflow             = overflow_q;
  assign frame_abort          = abort_q;
endmodule

// File: tb/tb_llr_bank_loader.sv
// tb/tb_llr_bank_loader.sv - directed self-checking bench for llr_bank_loader
module tb_llr_bank_loader;
  logic wrclk = 1'b0;
  logic reset, start_read, frame_lock, data_ack;
  always #5 wrclk = ~wrclk;

  llr_bank_loader_if #(.LLR_W(11), .NUM_BANKS(2), .ADDR_W(2))  seq_if ();
  llr_bank_loader_if #(.LLR_W(11), .NUM_BANKS(2), .ADDR_W(2))  rr_if ();
  llr_bank_loader_if #(.LLR_W(11), .NUM_BANKS(10), .ADDR_W(6)) def_if ();

  logic seq_rdy, seq_rd, seq_ovf, seq_abort;
  logic rr_rdy, rr_rd, rr_ovf, rr_abort;
  logic def_rdy, def_rd, def_ovf, def_abort;

  llr_bank_loader #(.LLR_W(11), .NUM_BANKS(2), .DEPTH(4), .INTERLEAVE(0)) u_seq (
    .wrclk(wrclk), .reset(reset), .start_read(start_read), .frame_lock(frame_lock), .bus(seq_if),
    .data_ready(seq_rdy), .rd_page(seq_rd), .data_ack(data_ack), .overflow(seq_ovf), .frame_abort(seq_abort));
  llr_bank_loader #(.LLR_W(11), .NUM_BANKS(2), .DEPTH(4), .INTERLEAVE(1)) u_rr (
    .wrclk(wrclk), .reset(reset), .start_read(start_read), .frame_lock(frame_lock), .bus(rr_if),
    .data_ready(rr_rdy), .rd_page(rr_rd), .data_ack(data_ack), .overflow(rr_ovf), .frame_abort(rr_abort));
  llr_bank_loader u_def (
    .wrclk(wrclk), .reset(reset), .start_read(start_read), .frame_lock(frame_lock), .bus(def_if),
    .data_ready(def_rdy), .rd_page(def_rd), .data_ack(data_ack), .overflow(def_ovf), .frame_abort(def_abort));

  int checks = 0;
  int errors = 0;
  logic [15:0] seq_log[$];
  logic [15:0] rr_log[$];
  int abort_cnt = 0;
  int def_cnt = 0;
  logic [9:0] def_last_wren;
  logic [5:0] def_last_addr;
  logic       def_last_page;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ent(input int bank, input int addr, input int page, input int data);
    return {11'(data), 1'(page), 2'(addr), 2'(1 << bank)};
  endfunction

  always @(negedge wrclk) begin
    if (seq_if.wren_Lch != '0)
      seq_log.push_back({seq_if.data_Lch, seq_if.wr_addr_high_Lch, seq_if.wr_addr_Lch, seq_if.wren_Lch});
    if (rr_if.wren_Lch != '0)
      rr_log.push_back({rr_if.data_Lch, rr_if.wr_addr_high_Lch, rr_if.wr_addr_Lch, rr_if.wren_Lch});
    if (seq_abort) abort_cnt++;
    if (def_if.wren_Lch != '0) begin
      def_cnt++;
      def_last_wren = def_if.wren_Lch;
      def_last_addr = def_if.wr_addr_Lch;
      def_last_page = def_if.wr_addr_high_Lch;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge wrclk);
      #1;
    end
  endtask

  task automatic send(input int dut, input logic [10:0] d);
    case (dut)
      0: begin seq_if.input_en = 1'b1; seq_if.data_in = d; end
      1: begin rr_if.input_en = 1'b1; rr_if.data_in = d; end
      default: begin def_if.input_en = 1'b1; def_if.data_in = d; end
    endcase
    idle(1);
    seq_if.input_en = 1'b0;
    rr_if.input_en  = 1'b0;
    def_if.input_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start_read = 1'b0;
    frame_lock = 1'b0;
    data_ack = 1'b0;
    seq_if.input_en = 1'b0; seq_if.data_in = '0;
    rr_if.input_en  = 1'b0; rr_if.data_in  = '0;
    def_if.input_en = 1'b0; def_if.data_in = '0;
    idle(2);
    reset = 1'b0;
    seq_log.delete();
    rr_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    @(negedge wrclk);
    do_reset();
    check_eq("rst_wren", seq_if.wren_Lch, 0);
    check_eq("rst_data_addr_page", {seq_if.data_Lch, seq_if.wr_addr_Lch, seq_if.wr_addr_high_Lch}, 0);
    check_eq("rst_status", {seq_rdy, seq_rd, seq_ovf, seq_abort, seq_if.in_ready}, 0);

    // sequential fill of one frame
    start_read = 1'b1;
    frame_lock = 1'b1;
    #1;
    check_eq("in_ready_on", seq_if.in_ready, 1);
    for (int i = 0; i < 8; i++) send(0, 11'(i + 1));
    check_eq("t1_ready_not_yet", seq_rdy, 0);
    idle(1);
    check_eq("t1_data_ready", seq_rdy, 1);
    check_eq("t1_rd_page", seq_rd, 0);
    check_eq("t1_log_size", seq_log.size(), 8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("t1_w%0d", i), (i < seq_log.size()) ? seq_log[i] : 16'hffff, ent(i / 4, i % 4, 0, i + 1));

    // round-robin fill of one frame
    for (int i = 0; i < 8; i++) send(1, 11'(i + 1));
    idle(1);
    check_eq("t2_data_ready", rr_rdy, 1);
    check_eq("t2_log_size", rr_log.size(), 8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("t2_w%0d", i), (i < rr_log.size()) ? rr_log[i] : 16'hffff, ent(i % 2, i / 2, 0, i + 1));

    // both pages filled, later words dropped
    do_reset();
    start_read = 1'b1;
    frame_lock = 1'b1;
    for (int i = 0; i < 24; i++) send(0, 11'(i + 1));
    check_eq("t3_in_ready_low", seq_if.in_ready, 0);
    check_eq("t3_overflow", seq_ovf, 1);
    check_eq("t3_data_ready", seq_rdy, 1);
    check_eq("t3_rd_page", seq_rd, 0);
    check_eq("t3_log_size", seq_log.size(), 16);
    check_eq("t3_w8", (seq_log.size() > 8) ? seq_log[8] : 16'hffff, ent(0, 0, 1, 9));
    check_eq("t3_w15", (seq_log.size() > 15) ? seq_log[15] : 16'hffff, ent(1, 3, 1, 16));
    data_ack = 1'b1;
    idle(1);
    data_ack = 1'b0;
    check_eq("t3_ack_rd_page", seq_rd, 1);
    check_eq("t3_ack_in_ready", seq_if.in_ready, 1);
    check_eq("t3_ack_data_ready", seq_rdy, 1);
    check_eq("t3_overflow_sticky", seq_ovf, 1);

    // frame_lock drop mid-frame
    do_reset();
    start_read = 1'b1;
    frame_lock = 1'b1;
    abort_cnt = 0;
    for (int i = 0; i < 5; i++) send(0, 11'(16 + i));
    frame_lock = 1'b0;
    idle(1);
    check_eq("t4_abort_pulse", seq_abort, 1);
    idle(1);
    check_eq("t4_abort_once", seq_abort, 0);
    frame_lock = 1'b1;
    seq_log.delete();
    send(0, 11'h100);
    idle(1);
    check_eq("t4_restart_pos", (seq_log.size() > 0) ? seq_log[0] : 16'hffff, ent(0, 0, 0, 'h100));
    check_eq("t4_data_ready", seq_rdy, 0);
    check_eq("t4_abort_cnt", abort_cnt, 1);
    abort_cnt = 0;

    // gaps and start_read low mid-frame
    send(0, 11'h101);
    idle(2);
    send(0, 11'h102);
    start_read = 1'b0;
    seq_if.input_en = 1'b1;
    seq_if.data_in = 11'h1ff;
    idle(20);
    seq_if.input_en = 1'b0;
    start_read = 1'b1;
    for (int i = 3; i < 8; i++) begin
      send(0, 11'(256 + i));
      if (i == 5) idle(3);
    end
    idle(1);
    check_eq("t5_log_size", seq_log.size(), 8);
    for (int i = 1; i < 8; i++)
      check_eq($sformatf("t5_w%0d", i), (i < seq_log.size()) ? seq_log[i] : 16'hffff, ent(i / 4, i % 4, 0, 256 + i));
    check_eq("t5_no_abort", abort_cnt, 0);
    check_eq("t5_no_overflow", seq_ovf, 0);
    check_eq("t5_data_ready", seq_rdy, 1);

    // ack coinciding with commit of second frame
    seq_log.delete();
    for (int i = 0; i < 8; i++) send(0, 11'(512 + i));
    data_ack = 1'b1;
    idle(1);
    data_ack = 1'b0;
    check_eq("t6_data_ready", seq_rdy, 1);
    check_eq("t6_rd_page", seq_rd, 1);
    check_eq("t6_last_w", (seq_log.size() > 7) ? seq_log[7] : 16'hffff, ent(1, 3, 1, 519));
    data_ack = 1'b1;
    idle(1);
    data_ack = 1'b0;
    check_eq("t6_empty", seq_rdy, 0);
    check_eq("t6_rd_page2", seq_rd, 0);
    data_ack = 1'b1;
    idle(1);
    data_ack = 1'b0;
    check_eq("t6_ack_ignored", seq_rd, 0);

    // default geometry, one full frame
    do_reset();
    start_read = 1'b1;
    frame_lock = 1'b1;
    def_cnt = 0;
    for (int i = 0; i < 640; i++) send(2, 11'(i));
    check_eq("t7_ready_not_yet", def_rdy, 0);
    idle(1);
    check_eq("t7_wren_count", def_cnt, 640);
    check_eq("t7_last_bank", def_last_wren, 10'h200);
    check_eq("t7_last_addr", def_last_addr, 63);
    check_eq("t7_last_page", def_last_page, 0);
    check_eq("t7_data_ready", def_rdy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
